// File: rtl/uart_echo_pkg.sv
// Shared state encodings and constants for the UART echo controller.
// Used by uart_echo_ctrl; the statistics width applies only when UART_ECHO_STATS_EN is defined.
package uart_echo_pkg;

   typedef enum logic {
      R_IDLE,
      R_ACK
   } rx_state_e;

   typedef enum logic [1:0] {
      T_IDLE,
      T_WAIT,
      T_SEND
   } tx_state_e;

   localparam int STAT_W = 16;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FIFO with a registered read port: data_o updates on the edge that pops.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          push_i,
   input  logic [DATA_W-1:0]             data_i,
   input  logic                          pop_i,
   output logic [DATA_W-1:0]             data_o,
   output logic                          full_o,
   output logic                          empty_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
   logic [AW-1:0]     wrPtr_q;
   logic [AW-1:0]     rdPtr_q;
   logic [AW:0]       level_q;
   logic [DATA_W-1:0] data_q;
   logic              pushOk;
   logic              popOk;

   assign full_o  = (level_q == (AW+1)'(FIFO_DEPTH));
   assign empty_o = (level_q == '0);
   assign popOk   = pop_i && !empty_o;
   assign pushOk  = push_i && (!full_o || popOk);
   assign data_o  = data_q;
   assign level_o = level_q;

   // Pointers are exactly AW bits wide, so they wrap modulo the power-of-two depth.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         level_q <= '0;
         data_q  <= '0;
      end else begin
         if (pushOk) begin
            wrPtr_q <= wrPtr_q + 1'b1;
         end
         if (popOk) begin
            rdPtr_q <= rdPtr_q + 1'b1;
            data_q  <= mem_q[rdPtr_q];
         end
         if (pushOk && !popOk) begin
            level_q <= level_q + 1'b1;
         end else if (popOk && !pushOk) begin
            level_q <= level_q - 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (pushOk) begin
         mem_q[wrPtr_q] <= data_i;
      end
   end

endmodule

// File: rtl/uart_echo_ctrl.sv
// Loopback controller between uart_rx and uart_tx: buffers, delays and echoes words, stretches activity pulses.
// Define UART_ECHO_STATS_EN to add saturating o_rx_count / o_tx_count statistics ports.
module uart_echo_ctrl
   import uart_echo_pkg::*;
#(
   parameter int DATA_W         = 8,
   parameter int FIFO_DEPTH     = 16,
   parameter int ECHO_DELAY_CYC = 2_000_000,
   parameter int PULSE_CYC      = 5_400_000
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_rx_done,
   input  logic [DATA_W-1:0]             i_rx_data,
   input  logic                          i_rx_frame_err,
   output logic                          o_rx_ack,
   output logic [DATA_W-1:0]             o_tx_data,
   output logic                          o_tx_valid,
   input  logic                          i_tx_ready,
   input  logic                          i_err_clr,
   output logic                          o_rx_pulse,
   output logic                          o_tx_pulse,
   output logic                          o_err_sticky,
   output logic                          o_overflow,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
`ifdef UART_ECHO_STATS_EN
   ,
   output logic [STAT_W-1:0]             o_rx_count,
   output logic [STAT_W-1:0]             o_tx_count
`endif
);

   localparam int CNT_W = (ECHO_DELAY_CYC > 1) ? $clog2(ECHO_DELAY_CYC) : 1;
   localparam int PLS_W = $clog2(PULSE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((ECHO_DELAY_CYC > 0) ? ECHO_DELAY_CYC - 1 : 0);
   localparam logic [PLS_W-1:0] PULSE_LOAD = PLS_W'(PULSE_CYC);

   rx_state_e          rxState_q, rxState_d;
   tx_state_e          txState_q, txState_d;
   logic               rxAck_q, rxAck_d;
   logic               txValid_q, txValid_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [PLS_W-1:0]   rxPls_q, rxPls_d;
   logic [PLS_W-1:0]   txPls_q, txPls_d;
   logic               errSticky_q, errSticky_d;
   logic               overflow_q, overflow_d;
   logic               pushReq;
   logic               popReq;
   logic               pushAcc;
   logic               pushDrop;
   logic               txAccept;
   logic               fifoFull;
   logic               fifoEmpty;

   uart_sync_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .push_i  (pushReq),
      .data_i  (i_rx_data),
      .pop_i   (popReq),
      .data_o  (o_tx_data),
      .full_o  (fifoFull),
      .empty_o (fifoEmpty),
      .level_o (o_fifo_level)
   );

   // popReq is only raised when the FIFO is non-empty, so it frees a slot this cycle.
   assign pushAcc  = pushReq && (!fifoFull || popReq);
   assign pushDrop = pushReq && fifoFull && !popReq;
   assign txAccept = txValid_q && i_tx_ready;

   always_comb begin
      rxState_d = rxState_q;
      rxAck_d   = rxAck_q;
      pushReq   = 1'b0;
      case (rxState_q)
         R_IDLE: begin
            if (i_rx_done) begin
               pushReq   = 1'b1;
               rxAck_d   = 1'b1;
               rxState_d = R_ACK;
            end
         end
         R_ACK: begin
            if (!i_rx_done) begin
               rxAck_d   = 1'b0;
               rxState_d = R_IDLE;
            end
         end
         default: begin
            rxAck_d   = 1'b0;
            rxState_d = R_IDLE;
         end
      endcase
   end

   always_comb begin
      txState_d = txState_q;
      txValid_d = txValid_q;
      cnt_d     = cnt_q;
      popReq    = 1'b0;
      case (txState_q)
         T_IDLE: begin
            if (!fifoEmpty) begin
               popReq = 1'b1;
               cnt_d  = '0;
               if (ECHO_DELAY_CYC == 0) begin
                  txValid_d = 1'b1;
                  txState_d = T_SEND;
               end else begin
                  txState_d = T_WAIT;
               end
            end
         end
         T_WAIT: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               txValid_d = 1'b1;
               txState_d = T_SEND;
            end
         end
         T_SEND: begin
            if (i_tx_ready) begin
               txValid_d = 1'b0;
               txState_d = T_IDLE;
            end
         end
         default: begin
            txValid_d = 1'b0;
            txState_d = T_IDLE;
         end
      endcase
   end

   // Pulse counters reload on every event, so back-to-back activity extends the pulse.
   always_comb begin
      rxPls_d = rxPls_q;
      txPls_d = txPls_q;
      if (pushAcc) begin
         rxPls_d = PULSE_LOAD;
      end else if (rxPls_q != '0) begin
         rxPls_d = rxPls_q - 1'b1;
      end
      if (txAccept) begin
         txPls_d = PULSE_LOAD;
      end else if (txPls_q != '0) begin
         txPls_d = txPls_q - 1'b1;
      end
      errSticky_d = i_rx_frame_err ? 1'b1 : (i_err_clr ? 1'b0 : errSticky_q);
      overflow_d  = pushDrop       ? 1'b1 : (i_err_clr ? 1'b0 : overflow_q);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rxState_q   <= R_IDLE;
         txState_q   <= T_IDLE;
         rxAck_q     <= 1'b0;
         txValid_q   <= 1'b0;
         cnt_q       <= '0;
         rxPls_q     <= '0;
         txPls_q     <= '0;
         errSticky_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         rxState_q   <= rxState_d;
         txState_q   <= txState_d;
         rxAck_q     <= rxAck_d;
         txValid_q   <= txValid_d;
         cnt_q       <= cnt_d;
         rxPls_q     <= rxPls_d;
         txPls_q     <= txPls_d;
         errSticky_q <= errSticky_d;
         overflow_q  <= overflow_d;
      end
   end

   assign o_rx_ack     = rxAck_q;
   assign o_tx_valid   = txValid_q;
   assign o_rx_pulse   = (rxPls_q != '0);
   assign o_tx_pulse   = (txPls_q != '0);
   assign o_err_sticky = errSticky_q;
   assign o_overflow   = overflow_q;

`ifdef UART_ECHO_STATS_EN
   logic [STAT_W-1:0] rxCount_q, rxCount_d;
   logic [STAT_W-1:0] txCount_q, txCount_d;

   // Clear takes priority over a same-cycle increment; both counters saturate.
   always_comb begin
      rxCount_d = rxCount_q;
      txCount_d = txCount_q;
      if (i_err_clr) begin
         rxCount_d = '0;
         txCount_d = '0;
      end else begin
         if (pushAcc && (rxCount_q != '1)) begin
            rxCount_d = rxCount_q + 1'b1;
         end
         if (txAccept && (txCount_q != '1)) begin
            txCount_d = txCount_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         rxCount_q <= '0;
         txCount_q <= '0;
      end else begin
         rxCount_q <= rxCount_d;
         txCount_q <= txCount_d;
      end
   end

   assign o_rx_count = rxCount_q;
   assign o_tx_count = txCount_q;
`endif

endmodule

// File: tb/tb_uart_echo_ctrl.sv
// Self-checking bench for uart_echo_ctrl with a small depth and short delays.
// Statistics checks are compiled in when UART_ECHO_STATS_EN is defined.
module tb_uart_echo_ctrl;

   localparam int DATA_W         = 8;
   localparam int FIFO_DEPTH     = 4;
   localparam int ECHO_DELAY_CYC = 4;
   localparam int PULSE_CYC      = 8;

   logic              i_clk = 1'b0;
   logic              i_rst;
   logic              i_rx_done;
   logic [DATA_W-1:0] i_rx_data;
   logic              i_rx_frame_err;
   logic              o_rx_ack;
   logic [DATA_W-1:0] o_tx_data;
   logic              o_tx_valid;
   logic              i_tx_ready;
   logic              i_err_clr;
   logic              o_rx_pulse;
   logic              o_tx_pulse;
   logic              o_err_sticky;
   logic              o_overflow;
   logic [2:0]        o_fifo_level;
`ifdef UART_ECHO_STATS_EN
   logic [15:0]       o_rx_count;
   logic [15:0]       o_tx_count;
`endif

   int checkCount = 0;
   int passCount  = 0;
   logic [DATA_W-1:0] accQ[$];
   logic [DATA_W-1:0] gotQ[$];

   always #5 i_clk = ~i_clk;

   uart_echo_ctrl #(
      .DATA_W         (DATA_W),
      .FIFO_DEPTH     (FIFO_DEPTH),
      .ECHO_DELAY_CYC (ECHO_DELAY_CYC),
      .PULSE_CYC      (PULSE_CYC)
   ) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_rx_done      (i_rx_done),
      .i_rx_data      (i_rx_data),
      .i_rx_frame_err (i_rx_frame_err),
      .o_rx_ack       (o_rx_ack),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .i_err_clr      (i_err_clr),
      .o_rx_pulse     (o_rx_pulse),
      .o_tx_pulse     (o_tx_pulse),
      .o_err_sticky   (o_err_sticky),
      .o_overflow     (o_overflow),
      .o_fifo_level   (o_fifo_level)
`ifdef UART_ECHO_STATS_EN
      ,
      .o_rx_count     (o_rx_count),
      .o_tx_count     (o_tx_count)
`endif
   );

   // One uart_rx handshake: word presented for one edge, then released for one edge.
   task automatic sendWord(input logic [DATA_W-1:0] d);
      i_rx_data = d;
      i_rx_done = 1'b1;
      @(posedge i_clk); #1;
      i_rx_done = 1'b0;
      @(posedge i_clk); #1;
   endtask

   // Records each echoed word; with ready high every valid is visible for exactly one sample.
   task automatic collectEchoes(input int n, input int budget);
      gotQ.delete();
      for (int c = 0; c < budget; c++) begin
         if (gotQ.size() >= n) break;
         if (o_tx_valid) gotQ.push_back(o_tx_data);
         @(posedge i_clk); #1;
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1; i_rx_done = 1'b0; i_rx_data = '0; i_rx_frame_err = 1'b0;
      i_tx_ready = 1'b1; i_err_clr = 1'b0;
      #1;
      checkCount++;
      if ({o_rx_ack, o_tx_valid, o_tx_data, o_rx_pulse, o_tx_pulse, o_err_sticky, o_overflow, o_fifo_level} !== '0)
         $display("[TB] FAIL reset_outputs: got %b required all zero",
                  {o_rx_ack, o_tx_valid, o_tx_data, o_rx_pulse, o_tx_pulse, o_err_sticky, o_overflow, o_fifo_level});
      else passCount++;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      @(posedge i_clk); #1;
   endtask

   task automatic test_single();
      int rxHigh;
      int validAt;
      logic [DATA_W-1:0] seen;
      validAt = -1; seen = '0;
      i_tx_ready = 1'b1;
      i_rx_data  = 8'hA5;
      i_rx_done  = 1'b1;
      @(posedge i_clk); #1;
      checkCount++;
      if (o_rx_ack !== 1'b1) $display("[TB] FAIL single_ack_high: got %b required 1", o_rx_ack);
      else passCount++;
      i_rx_done = 1'b0;
      rxHigh = o_rx_pulse ? 1 : 0;
      for (int n = 1; n <= 15; n++) begin
         @(posedge i_clk); #1;
         if (n == 1) begin
            checkCount++;
            if (o_rx_ack !== 1'b0) $display("[TB] FAIL single_ack_low: got %b required 0", o_rx_ack);
            else passCount++;
         end
         if (o_rx_pulse) rxHigh++;
         if (o_tx_valid && validAt < 0) begin
            validAt = n;
            seen    = o_tx_data;
         end
      end
      checkCount++;
      if (validAt !== 1 + ECHO_DELAY_CYC)
         $display("[TB] FAIL single_latency: got %0d required %0d", validAt, 1 + ECHO_DELAY_CYC);
      else passCount++;
      checkCount++;
      if (seen !== 8'hA5) $display("[TB] FAIL single_data: got %h required a5", seen);
      else passCount++;
      checkCount++;
      if (rxHigh !== PULSE_CYC) $display("[TB] FAIL single_rx_pulse: got %0d required %0d", rxHigh, PULSE_CYC);
      else passCount++;
   endtask

   // Model: while the transmitter is stalled it holds one word, plus FIFO_DEPTH buffered words.
   task automatic test_burst();
      int drops;
      logic [DATA_W-1:0] d;
      drops = 0;
      accQ.delete();
      i_tx_ready = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d = DATA_W'($urandom);
         sendWord(d);
         if (accQ.size() < FIFO_DEPTH + 1) accQ.push_back(d);
         else drops++;
      end
      checkCount++;
      if (int'(o_fifo_level) !== accQ.size() - 1)
         $display("[TB] FAIL burst_level: got %0d required %0d", o_fifo_level, accQ.size() - 1);
      else passCount++;
      checkCount++;
      if (o_overflow !== (drops > 0))
         $display("[TB] FAIL burst_overflow: got %b required %b", o_overflow, drops > 0);
      else passCount++;
      i_tx_ready = 1'b1;
      collectEchoes(accQ.size(), 200);
      checkCount++;
      if (gotQ.size() !== accQ.size())
         $display("[TB] FAIL burst_echo_count: got %0d required %0d", gotQ.size(), accQ.size());
      else passCount++;
      for (int i = 0; i < accQ.size() && i < gotQ.size(); i++) begin
         checkCount++;
         if (gotQ[i] !== accQ[i]) $display("[TB] FAIL burst_echo_%0d: got %h required %h", i, gotQ[i], accQ[i]);
         else passCount++;
      end
   endtask

   task automatic test_sticky();
      i_rx_frame_err = 1'b1;
      @(posedge i_clk); #1;
      i_rx_frame_err = 1'b0;
      checkCount++;
      if (o_err_sticky !== 1'b1) $display("[TB] FAIL sticky_set: got %b required 1", o_err_sticky);
      else passCount++;
      i_rx_frame_err = 1'b1; i_err_clr = 1'b1;
      @(posedge i_clk); #1;
      i_rx_frame_err = 1'b0;
      checkCount++;
      if (o_err_sticky !== 1'b1) $display("[TB] FAIL sticky_set_wins: got %b required 1", o_err_sticky);
      else passCount++;
      @(posedge i_clk); #1;
      i_err_clr = 1'b0;
      checkCount++;
      if (o_err_sticky !== 1'b0) $display("[TB] FAIL sticky_clear: got %b required 0", o_err_sticky);
      else passCount++;
      checkCount++;
      if (o_overflow !== 1'b0) $display("[TB] FAIL overflow_clear: got %b required 0", o_overflow);
      else passCount++;
   endtask

   task automatic test_stall();
      logic [DATA_W-1:0] d;
      logic stable;
      int txHigh;
      d = DATA_W'($urandom);
      i_tx_ready = 1'b0;
      sendWord(d);
      for (int c = 0; c < 20 && !o_tx_valid; c++) begin
         @(posedge i_clk); #1;
      end
      checkCount++;
      if (o_tx_valid !== 1'b1 || o_tx_data !== d)
         $display("[TB] FAIL stall_valid: got valid %b data %h required valid 1 data %h", o_tx_valid, o_tx_data, d);
      else passCount++;
      stable = 1'b1;
      repeat (20) begin
         @(posedge i_clk); #1;
         if (o_tx_valid !== 1'b1 || o_tx_data !== d) stable = 1'b0;
      end
      checkCount++;
      if (stable !== 1'b1) $display("[TB] FAIL stall_hold: got stable %b required 1", stable);
      else passCount++;
      i_tx_ready = 1'b1;
      @(posedge i_clk); #1;
      checkCount++;
      if (o_tx_valid !== 1'b0) $display("[TB] FAIL stall_release: got %b required 0", o_tx_valid);
      else passCount++;
      txHigh = o_tx_pulse ? 1 : 0;
      repeat (11) begin
         @(posedge i_clk); #1;
         if (o_tx_pulse) txHigh++;
      end
      checkCount++;
      if (txHigh !== PULSE_CYC) $display("[TB] FAIL stall_tx_pulse: got %0d required %0d", txHigh, PULSE_CYC);
      else passCount++;
   endtask

   task automatic test_reset_mid_wait();
      int validSeen;
      i_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         i_rx_data = DATA_W'($urandom);
         i_rx_done = 1'b1;
         @(posedge i_clk); #1;
         if (i < 2) begin
            i_rx_done = 1'b0;
            @(posedge i_clk); #1;
         end
      end
      checkCount++;
      if (o_fifo_level !== 3'd2 || o_tx_valid !== 1'b0)
         $display("[TB] FAIL midwait_state: got level %0d valid %b required level 2 valid 0", o_fifo_level, o_tx_valid);
      else passCount++;
      i_rst = 1'b1;
      #1;
      checkCount++;
      if ({o_rx_ack, o_tx_valid, o_tx_data, o_rx_pulse, o_tx_pulse, o_fifo_level} !== '0)
         $display("[TB] FAIL midwait_reset_outputs: got %b required all zero",
                  {o_rx_ack, o_tx_valid, o_tx_data, o_rx_pulse, o_tx_pulse, o_fifo_level});
      else passCount++;
      i_rx_done = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst = 1'b0;
      validSeen = 0;
      repeat (40) begin
         @(posedge i_clk); #1;
         if (o_tx_valid) validSeen++;
      end
      checkCount++;
      if (validSeen !== 0 || o_fifo_level !== 3'd0)
         $display("[TB] FAIL midwait_no_echo: got %0d echoes level %0d required 0 echoes level 0", validSeen, o_fifo_level);
      else passCount++;
   endtask

   task automatic test_back_to_back();
      logic [DATA_W-1:0] d;
      accQ.delete();
      i_tx_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = DATA_W'($urandom);
         sendWord(d);
         accQ.push_back(d);
      end
      collectEchoes(3, 100);
      @(posedge i_clk); #1;
      checkCount++;
      if (gotQ.size() !== 3) $display("[TB] FAIL b2b_echo_count: got %0d required 3", gotQ.size());
      else passCount++;
      for (int i = 0; i < 3 && i < gotQ.size(); i++) begin
         checkCount++;
         if (gotQ[i] !== accQ[i]) $display("[TB] FAIL b2b_echo_%0d: got %h required %h", i, gotQ[i], accQ[i]);
         else passCount++;
      end
`ifdef UART_ECHO_STATS_EN
      checkCount++;
      if (o_rx_count !== 16'd3) $display("[TB] FAIL stats_rx_count: got %0d required 3", o_rx_count);
      else passCount++;
      checkCount++;
      if (o_tx_count !== 16'd3) $display("[TB] FAIL stats_tx_count: got %0d required 3", o_tx_count);
      else passCount++;
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_sticky();
      test_stall();
      test_reset_mid_wait();
      test_back_to_back();
      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
